// File: rtl/mux_4_1_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_4_1_arbiter
// Description : Four-requester round-robin arbiter driving a shared 4:1 mux.
//               A request seen in IDLE is granted on the next edge. The data
//               bit of the granted requester is registered onto y. Every
//               release goes through one IDLE cycle before the next grant.
// Options     : MUX_ARB_TIMEOUT_EN - when defined, a grant is forcibly
//               released after MAX_HOLD consecutive grant cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4_1_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] in,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       y,
  output logic       valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Saturation point of the hold counter so it never wraps inside one grant.
  localparam logic [7:0] HOLD_SAT = 8'hFF;

  // Reject out-of-range hold limits at elaboration time.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_check
    $error("mux_4_1_arbiter: MAX_HOLD must lie in 1..255");
  end

  state_t     state_q, state_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [1:0] sel_q,   sel_d;
  logic [7:0] hold_q,  hold_d;
  logic       y_q,     y_d;
  logic       valid_q, valid_d;

  logic       arb_hit;
  logic [1:0] arb_idx;
  logic       release_req;
  logic       timeout;

  // Round-robin search: the first set request at ptr, ptr+1, ptr+2, ptr+3.
  // The loop runs from the farthest offset down so the nearest one wins.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr_q + 2'(i)]) begin
        arb_hit = 1'b1;
        arb_idx = ptr_q + 2'(i);
      end
    end
  end

  // Release conditions for the current grant: requester drops its line, or
  // the optional hold limit is reached. Both lead to the same next state.
  always_comb begin
    release_req = ~req[sel_q];
`ifdef MUX_ARB_TIMEOUT_EN
    // hold_q counts grant cycles already completed before this edge, so the
    // edge closing the MAX_HOLD-th grant cycle sees MAX_HOLD-1.
    timeout = (hold_q == 8'(MAX_HOLD - 1));
`else
    timeout = 1'b0;
`endif
  end

  // Next-state logic for the arbiter FSM, pointer, hold counter and datapath.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    y_d     = y_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // y keeps its last value and valid drops while nobody is granted.
        if (arb_hit) begin
          state_d = GRANT;
          sel_d   = arb_idx;
          hold_d  = 8'd0;
        end
      end

      GRANT: begin
        y_d     = in[sel_q];
        valid_d = 1'b1;
        if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 8'd1;
        end
        // Requests on the other lines are ignored here; only the granted
        // line (or the hold limit) can end the grant.
        if (release_req || timeout) begin
          state_d = IDLE;
          ptr_d   = sel_q + 2'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset clears everything immediately, without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      hold_q  <= 8'd0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  // Grant is decoded from registered state, so it is one-hot by construction
  // and falls as soon as reset forces the state back to IDLE.
  always_comb begin
    gnt = 4'b0000;
    if (state_q == GRANT) begin
      gnt = 4'b0001 << sel_q;
    end
  end

  assign sel   = sel_q;
  assign y     = y_q;
  assign valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_4_1_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_4_1_arbiter
// Description : Directed bench for mux_4_1_arbiter: a vector table for the
//               single-cycle behaviour plus hand sequences for reset,
//               fairness and hold-limit behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_4_1_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       y;
  logic       valid;

  int checks;
  int errors;

  mux_4_1_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .in    (din),
    .gnt   (gnt),
    .sel   (sel),
    .y     (y),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       y;
    logic       valid;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = 4'b0000;
    din    = 4'b0000;

    //            req      din      gnt      sel    y     valid
    vecs[0]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0};
    vecs[1]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[2]  = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1};
    vecs[3]  = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[4]  = '{4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b0, 1'b0};
    vecs[5]  = '{4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    vecs[6]  = '{4'b0001, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b1};
    vecs[7]  = '{4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0};
    vecs[8]  = '{4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[9]  = '{4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1};
    vecs[10] = '{4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b0, 1'b0};
    vecs[11] = '{4'b1001, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1};
    vecs[12] = '{4'b1011, 4'b0111, 4'b1000, 2'd3, 1'b0, 1'b1};
    vecs[13] = '{4'b0111, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b1};
    vecs[14] = '{4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0};
    vecs[15] = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
    vecs[16] = '{4'b0010, 4'b1101, 4'b0010, 2'd1, 1'b0, 1'b1};
    vecs[17] = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
    vecs[18] = '{4'b0000, 4'b1101, 4'b0000, 2'd1, 1'b0, 1'b1};
    vecs[19] = '{4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0};

    // Reset must act before any clock edge has occurred.
    #1;
    check("rst_async_gnt",   32'(gnt),   32'h0);
    check("rst_async_valid", 32'(valid), 32'h0);
    step();
    step();
    check("rst_gnt",   32'(gnt),   32'h0);
    check("rst_sel",   32'(sel),   32'h0);
    check("rst_y",     32'(y),     32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    rst = 1'b0;

    // Table: single requester, wrap-around, ignored non-granted lines, data path.
    for (int i = 0; i < NVEC; i++) begin
      req = vecs[i].req;
      din = vecs[i].din;
      step();
      check($sformatf("vec%0d_gnt", i),   32'(gnt),   32'(vecs[i].gnt));
      check($sformatf("vec%0d_sel", i),   32'(sel),   32'(vecs[i].sel));
      check($sformatf("vec%0d_y", i),     32'(y),     32'(vecs[i].y));
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d_onehot", i), 32'($countones(gnt) <= 1), 32'h1);
    end

    // Asynchronous reset in the middle of a grant to requester 1 (ptr is 2).
    req = 4'b0010;
    din = 4'b0010;
    step();
    check("ar_gnt_pre", 32'(gnt), 32'h2);
    step();
    check("ar_valid_pre", 32'(valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_gnt_drop",   32'(gnt),   32'h0);
    check("ar_valid_drop", 32'(valid), 32'h0);
    check("ar_sel_drop",   32'(sel),   32'h0);
    step();
    rst = 1'b0;
    req = 4'b1111;
    step();
    check("ar_first_gnt", 32'(gnt), 32'h1);

    // Fairness: all lines requesting, each drops after three grant cycles.
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (k % 4);
      check($sformatf("rr%0d_grant", k), 32'(gnt), 32'(exp_g));
      for (int j = 0; j < 2; j++) begin
        step();
        check($sformatf("rr%0d_hold", k), 32'(gnt), 32'(exp_g));
      end
      req = 4'b1111 & ~exp_g;
      step();
      check($sformatf("rr%0d_gap", k), 32'(gnt), 32'h0);
      req = 4'b1111;
      step();
    end
    check("rr_next", 32'(gnt), 32'h2);

    // Hold limit: requesters 0 and 1 keep their lines high.
    rst = 1'b1;
    req = 4'b0011;
    #1;
    step();
    rst = 1'b0;
    step();
    check("to_first", 32'(gnt), 32'h1);
`ifdef MUX_ARB_TIMEOUT_EN
    for (int j = 0; j < 3; j++) begin
      step();
      check("to_hold0", 32'(gnt), 32'h1);
    end
    step();
    check("to_gap0", 32'(gnt), 32'h0);
    step();
    check("to_grant1", 32'(gnt), 32'h2);
    for (int j = 0; j < 3; j++) begin
      step();
      check("to_hold1", 32'(gnt), 32'h2);
    end
    step();
    check("to_gap1", 32'(gnt), 32'h0);
    step();
    check("to_grant0", 32'(gnt), 32'h1);
`else
    for (int j = 0; j < 12; j++) begin
      step();
      check("to_persist", 32'(gnt), 32'h1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_4_1_arbiter.md
MUX_4_1_ARBITER -- requirements
Module: mux_4_1_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, range 1..255; maximum consecutive grant cycles per requester when the timeout is compiled in.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req  input  4  request lines; bit i is requester i; held high by a requester for the whole transfer.
REQ-005 Port: in  input  4  data lines; bit i is requester i's data bit into the shared 4:1 mux.
REQ-006 Port: gnt  output  4  one-hot grant, or all zero when idle.
REQ-007 Port: sel  output  2  mux select; index of the current or last granted requester.
REQ-008 Port: y  output  1  registered mux output, in[sel] sampled one cycle earlier.
REQ-009 Port: valid  output  1  high when y carries data from a granted requester.

Function
REQ-010 The block SHALL have two states: IDLE (gnt=0000) and GRANT (gnt one-hot, gnt[sel]=1).
REQ-011 The block SHALL keep a 2-bit round-robin pointer ptr; arbitration searches ptr, ptr+1, ptr+2, ptr+3 mod 4 and picks the first set req bit.
REQ-012 In IDLE with req!=0000 sampled at edge N, the block SHALL enter GRANT at edge N, driving gnt and sel from edge N (one-cycle request-to-grant latency).
REQ-013 In IDLE with req=0000, the block SHALL stay in IDLE; sel SHALL hold its last value.
REQ-014 In GRANT, y SHALL register in[sel] and valid SHALL register 1 each cycle; in IDLE, valid SHALL register 0 and y SHALL hold its value.
REQ-015 In GRANT, if req[sel] is sampled low, the block SHALL return to IDLE and set ptr=sel+1 mod 4 (3 wraps to 0).
REQ-016 Every release SHALL spend exactly one IDLE cycle (gnt=0000) before any new grant; there SHALL be no back-to-back grant handoff.
REQ-017 Changes on non-granted req bits during GRANT SHALL have no effect on gnt, sel or state.
REQ-018 A hold counter SHALL clear on entry to GRANT and increment each GRANT cycle; it SHALL be 8 bits wide and never wrap within one grant.
REQ-019 gnt SHALL never have more than one bit set, in any cycle.

Reset
REQ-020 While rst=1, regardless of clk: state=IDLE, gnt=0000, sel=00, y=0, valid=0, ptr=00, hold counter=0.
REQ-021 Reset asserted mid-grant SHALL drop gnt and valid immediately, without waiting for a clock edge.
REQ-022 After rst deasserts, the first arbitration SHALL start from ptr=0.

Configuration
REQ-023 Macro MUX_ARB_TIMEOUT_EN SHALL control forced release.
REQ-024 With MUX_ARB_TIMEOUT_EN defined: after MAX_HOLD GRANT cycles with req[sel] still high, the block SHALL force IDLE and set ptr=sel+1 mod 4. The requester's line stays high and it is granted again only when the round-robin search reaches it.
REQ-025 With MUX_ARB_TIMEOUT_EN defined: req[sel] falling in the same cycle as the timeout SHALL be handled as a normal release, with an identical result.
REQ-026 Without MUX_ARB_TIMEOUT_EN: no forced release; a grant SHALL last until req[sel] falls. The hold counter and MAX_HOLD SHALL have no functional effect.

Verification
REQ-027 Single requester: reset, req=0100, in=0100. Next edge: gnt=0100, sel=10. One edge later: y=1, valid=1. Drop req: gnt=0000 next edge, ptr=11.
REQ-028 Round-robin fairness: req=1111 held, each requester drops after 3 grant cycles and re-raises. Grant order SHALL be 0,1,2,3,0 with one IDLE cycle between each grant.
REQ-029 Wrap-around: ptr=11 after a grant to 2; req=1001. Grant SHALL go to 3, then 0, then 3.
REQ-030 Timeout (MUX_ARB_TIMEOUT_EN, MAX_HOLD=4): req=0011 held. gnt=0001 for exactly 4 cycles, one IDLE cycle, then gnt=0010 for 4 cycles. Without the macro, gnt=0001 persists indefinitely.
REQ-031 Async reset mid-grant: gnt=0010, assert rst between edges. gnt=0000 and valid=0 before the next edge; after release with req=1111, first grant SHALL be gnt=0001.
REQ-032 Data path: grant to 1, toggle in[1] every cycle. y SHALL follow in[1] with one-cycle delay; toggles on in[0], in[2], in[3] SHALL never appear on y.
